// File: rtl/id_stage_pipe.sv
// Decode stage of a 5-stage pipeline: register file, hazard detection, branch resolution
// with MEM/WB operand forwarding, and the ID/EX pipeline register.
module id_stage_pipe #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int CTRL_W     = 16,
   parameter int LOAD_STALL = 1,
   localparam int AW        = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc4,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [AW-1:0]     id_dst,
   input  logic              id_wen,
   input  logic              id_load,
   input  logic              id_branch,
   input  logic              id_bne,
   input  logic [XLEN-1:0]   id_imm,

   input  logic              mem_wen,
   input  logic              mem_load,
   input  logic [AW-1:0]     mem_dst,
   input  logic [XLEN-1:0]   mem_data,

   input  logic              wb_wen,
   input  logic [AW-1:0]     wb_dst,
   input  logic [XLEN-1:0]   wb_data,

   input  logic              flush,

   output logic              stall_out,
   output logic              br_taken,
   output logic [XLEN-1:0]   br_target,

   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_rs_data,
   output logic [XLEN-1:0]   ex_rt_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc4,
   output logic [AW-1:0]     ex_dst,
   output logic              ex_wen,
   output logic              ex_load
);

   // Counter holds the stall cycles still owed after the detecting cycle.
   localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

   logic [XLEN-1:0] regs [NREG];
   logic [1:0]      stall_cnt_q, stall_cnt_d;

   logic [XLEN-1:0] rs_val, rt_val;
   logic [XLEN-1:0] rs_br, rt_br;
   logic            lu_hit, br_ex_hit, br_mem_hit, load_stall;
   logic            br_eq;

   function automatic logic uses_reg(input logic [AW-1:0] d,
                                     input logic [AW-1:0] rs,
                                     input logic [AW-1:0] rt,
                                     input logic          rs_u,
                                     input logic          rt_u);
      return (d != '0) && ((rs_u && (rs == d)) || (rt_u && (rt == d)));
   endfunction

   // Register file reads with write-through from the WB port.
   always_comb begin
      rs_val = regs[id_rs];
      if (id_rs == '0) begin
         rs_val = '0;
      end else if (wb_wen && (wb_dst == id_rs)) begin
         rs_val = wb_data;
      end
   end

   always_comb begin
      rt_val = regs[id_rt];
      if (id_rt == '0) begin
         rt_val = '0;
      end else if (wb_wen && (wb_dst == id_rt)) begin
         rt_val = wb_data;
      end
   end

   // Branch comparator operands: an ALU result in MEM beats the WB/register file value.
   always_comb begin
      rs_br = rs_val;
      if (mem_wen && !mem_load && (mem_dst != '0) && (mem_dst == id_rs)) begin
         rs_br = mem_data;
      end
   end

   always_comb begin
      rt_br = rt_val;
      if (mem_wen && !mem_load && (mem_dst != '0) && (mem_dst == id_rt)) begin
         rt_br = mem_data;
      end
   end

   always_comb begin
      lu_hit     = id_valid && ex_valid && ex_load && ex_wen &&
                   uses_reg(ex_dst, id_rs, id_rt, id_rs_used, id_rt_used);
      br_ex_hit  = id_branch && ex_valid && ex_wen && !ex_load &&
                   uses_reg(ex_dst, id_rs, id_rt, id_rs_used, id_rt_used);
      br_mem_hit = id_branch && mem_wen && mem_load &&
                   uses_reg(mem_dst, id_rs, id_rt, id_rs_used, id_rt_used);
      load_stall = (stall_cnt_q != 2'd0) || lu_hit;
   end

   always_comb begin
      stall_out = !rst && id_valid && !flush && (load_stall || br_ex_hit || br_mem_hit);
      br_eq     = (rs_br == rt_br);
      br_taken  = !rst && id_valid && id_branch && !stall_out && !flush && (br_eq ^ id_bne);
      br_target = id_pc4 + (id_imm << 2);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         stall_cnt_d = 2'd0;
      end else if (stall_cnt_q != 2'd0) begin
         stall_cnt_d = stall_cnt_q - 2'd1;
      end else if (lu_hit) begin
         stall_cnt_d = STALL_INIT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 2'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Register 0 is never written, so it stays at its reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_wen && (wb_dst != '0)) begin
         regs[wb_dst] <= wb_data;
      end
   end

   // Bubbles clear only the qualifiers; payload fields keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_pc4     <= '0;
         ex_dst     <= '0;
         ex_wen     <= 1'b0;
         ex_load    <= 1'b0;
      end else if (flush || stall_out || !id_valid) begin
         ex_valid   <= 1'b0;
         ex_wen     <= 1'b0;
         ex_load    <= 1'b0;
      end else begin
         ex_valid   <= 1'b1;
         ex_ctrl    <= id_ctrl;
         ex_rs_data <= rs_val;
         ex_rt_data <= rt_val;
         ex_imm     <= id_imm;
         ex_pc4     <= id_pc4;
         ex_dst     <= id_dst;
         ex_wen     <= id_wen;
         ex_load    <= id_load;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized scoreboard bench for id_stage_pipe against a behavioural pipeline model.
module tb_id_stage_pipe;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int CTRL_W = 16;
   localparam int LS     = 3;
   localparam int AW     = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic              id_valid, id_rs_used, id_rt_used, id_wen, id_load, id_branch, id_bne;
   logic [XLEN-1:0]   id_pc4, id_imm, mem_data, wb_data;
   logic [AW-1:0]     id_rs, id_rt, id_dst, mem_dst, wb_dst;
   logic [CTRL_W-1:0] id_ctrl;
   logic              mem_wen, mem_load, wb_wen, flush;

   logic              stall_out, br_taken, ex_valid, ex_wen, ex_load;
   logic [XLEN-1:0]   br_target, ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [AW-1:0]     ex_dst;

   id_stage_pipe #(
      .XLEN       (XLEN),
      .NREG       (NREG),
      .CTRL_W     (CTRL_W),
      .LOAD_STALL (LS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_pc4     (id_pc4),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_ctrl    (id_ctrl),
      .id_dst     (id_dst),
      .id_wen     (id_wen),
      .id_load    (id_load),
      .id_branch  (id_branch),
      .id_bne     (id_bne),
      .id_imm     (id_imm),
      .mem_wen    (mem_wen),
      .mem_load   (mem_load),
      .mem_dst    (mem_dst),
      .mem_data   (mem_data),
      .wb_wen     (wb_wen),
      .wb_dst     (wb_dst),
      .wb_data    (wb_data),
      .flush      (flush),
      .stall_out  (stall_out),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .ex_valid   (ex_valid),
      .ex_ctrl    (ex_ctrl),
      .ex_rs_data (ex_rs_data),
      .ex_rt_data (ex_rt_data),
      .ex_imm     (ex_imm),
      .ex_pc4     (ex_pc4),
      .ex_dst     (ex_dst),
      .ex_wen     (ex_wen),
      .ex_load    (ex_load)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            stall;
      logic            taken;
      logic            chk_tgt;
      logic [XLEN-1:0] tgt;
   } comb_exp_t;

   typedef struct {
      logic              v;
      logic              wen;
      logic              load;
      logic [AW-1:0]     dst;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   rs;
      logic [XLEN-1:0]   rt;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc4;
   } ex_exp_t;

   comb_exp_t comb_q[$];
   ex_exp_t   ex_q[$];
   int        n_cmp = 0;
   int        n_err = 0;

   // Architectural model: register contents, what sits in EX, stall cycles still owed.
   logic [XLEN-1:0] m_regs [NREG];
   ex_exp_t         m_ex;
   int              m_stall_left;

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wb_wen && wb_dst == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a);
      if (a != 0 && mem_wen && !mem_load && mem_dst == a) return mem_data;
      return rd(a);
   endfunction

   function automatic logic uses(input logic [AW-1:0] d);
      return d != 0 && ((id_rs_used && id_rs == d) || (id_rt_used && id_rt == d));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_ex.v = 0; m_ex.wen = 0; m_ex.load = 0; m_ex.dst = '0; m_ex.ctrl = '0;
      m_ex.rs = '0; m_ex.rt = '0; m_ex.imm = '0; m_ex.pc4 = '0;
      m_stall_left = 0;
   endtask

   // Evaluate one cycle of the model on the currently driven inputs.
   task automatic step();
      comb_exp_t c;
      ex_exp_t   n;
      logic      lu, bex, bmem, stall, eq;
      lu   = id_valid && m_ex.v && m_ex.load && m_ex.wen && uses(m_ex.dst);
      if (m_stall_left == 0 && lu) m_stall_left = LS;
      bex  = id_branch && m_ex.v && m_ex.wen && !m_ex.load && uses(m_ex.dst);
      bmem = id_branch && mem_wen && mem_load && uses(mem_dst);
      stall = id_valid && !flush && (m_stall_left > 0 || bex || bmem);
      eq = (fwd(id_rs) == fwd(id_rt));
      c.stall   = stall;
      c.taken   = id_valid && id_branch && !stall && !flush && (eq != id_bne);
      c.chk_tgt = id_branch;
      c.tgt     = id_pc4 + id_imm * 4;
      comb_q.push_back(c);
      n = m_ex;
      if (flush || stall || !id_valid) begin
         n.v = 0; n.wen = 0; n.load = 0;
      end else begin
         n.v = 1; n.wen = id_wen; n.load = id_load; n.dst = id_dst; n.ctrl = id_ctrl;
         n.rs = rd(id_rs); n.rt = rd(id_rt); n.imm = id_imm; n.pc4 = id_pc4;
      end
      ex_q.push_back(n);
      m_ex = n;
      if (flush) m_stall_left = 0;
      else if (m_stall_left > 0) m_stall_left--;
      if (wb_wen && wb_dst != 0) m_regs[wb_dst] = wb_data;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_pc4 = '0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
      id_ctrl = '0; id_dst = '0; id_wen = 0; id_load = 0; id_branch = 0; id_bne = 0;
      id_imm = '0; mem_wen = 0; mem_load = 0; mem_dst = '0; mem_data = '0;
      wb_wen = 0; wb_dst = '0; wb_data = '0; flush = 0;
   endtask

   task automatic next();
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic rand_inputs();
      id_valid   = ($urandom_range(0, 99) < 85);
      id_pc4     = $urandom;
      id_rs      = AW'($urandom_range(0, 3));
      id_rt      = AW'($urandom_range(0, 3));
      id_rs_used = ($urandom_range(0, 3) != 0);
      id_rt_used = ($urandom_range(0, 3) != 0);
      id_ctrl    = CTRL_W'($urandom);
      id_dst     = AW'($urandom_range(0, 3));
      id_wen     = ($urandom_range(0, 9) < 7);
      id_load    = ($urandom_range(0, 99) < 35);
      id_branch  = ($urandom_range(0, 9) < 3);
      id_bne     = 1'($urandom_range(0, 1));
      id_imm     = $urandom;
      mem_wen    = ($urandom_range(0, 9) < 4);
      mem_load   = 1'($urandom_range(0, 1));
      mem_dst    = AW'($urandom_range(0, 3));
      mem_data   = ($urandom_range(0, 1) != 0) ? XLEN'($urandom_range(0, 3)) : $urandom;
      wb_wen     = 1'($urandom_range(0, 1));
      wb_dst     = AW'($urandom_range(0, 3));
      wb_data    = ($urandom_range(0, 1) != 0) ? XLEN'($urandom_range(0, 3)) : $urandom;
      flush      = ($urandom_range(0, 99) < 8);
   endtask

   always @(negedge clk) begin
      comb_exp_t c;
      #2;
      if (comb_q.size() > 0) begin
         c = comb_q.pop_front();
         check("stall_out", XLEN'(stall_out), XLEN'(c.stall));
         check("br_taken", XLEN'(br_taken), XLEN'(c.taken));
         if (c.chk_tgt) check("br_target", br_target, c.tgt);
      end
   end

   always @(posedge clk) begin
      ex_exp_t e;
      #1;
      if (ex_q.size() > 0) begin
         e = ex_q.pop_front();
         check("ex_valid", XLEN'(ex_valid), XLEN'(e.v));
         check("ex_wen", XLEN'(ex_wen), XLEN'(e.wen));
         check("ex_load", XLEN'(ex_load), XLEN'(e.load));
         check("ex_dst", XLEN'(ex_dst), XLEN'(e.dst));
         check("ex_ctrl", XLEN'(ex_ctrl), XLEN'(e.ctrl));
         check("ex_rs_data", ex_rs_data, e.rs);
         check("ex_rt_data", ex_rt_data, e.rt);
         check("ex_imm", ex_imm, e.imm);
         check("ex_pc4", ex_pc4, e.pc4);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      #1 rst = 1'b1;
      // Branch r0==r0 during reset must not redirect.
      id_valid = 1; id_branch = 1;
      #11;
      check("rst_ex_valid", XLEN'(ex_valid), '0);
      check("rst_ex_rs_data", ex_rs_data, '0);
      check("rst_ex_pc4", ex_pc4, '0);
      check("rst_stall_out", XLEN'(stall_out), '0);
      check("rst_br_taken", XLEN'(br_taken), '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // WB write-through into the read port.
      next(); wb_wen = 1; wb_dst = 5; wb_data = 32'hDEADBEEF;
      id_valid = 1; id_rs = 5; id_rs_used = 1; step();
      next(); step();

      // Load-use: LS stall cycles, then the consumer is captured.
      next(); id_valid = 1; id_load = 1; id_wen = 1; id_dst = 3; step();
      repeat (LS + 1) begin
         next(); id_valid = 1; id_rs = 3; id_rs_used = 1; id_dst = 4; id_wen = 1; step();
      end

      // Flush on the second stall cycle ends the stall.
      next(); id_valid = 1; id_load = 1; id_wen = 1; id_dst = 3; step();
      next(); id_valid = 1; id_rt = 3; id_rt_used = 1; step();
      next(); id_valid = 1; id_rt = 3; id_rt_used = 1; flush = 1; step();
      next(); id_valid = 1; id_rt = 3; id_rt_used = 1; step();

      // beq on an ALU result in EX: one stall, then MEM forwarding resolves it.
      next(); wb_wen = 1; wb_dst = 2; wb_data = 77; step();
      next(); id_valid = 1; id_dst = 1; id_wen = 1; step();
      next(); id_valid = 1; id_branch = 1; id_rs = 1; id_rt = 2; id_rs_used = 1;
      id_rt_used = 1; id_pc4 = 32'h100; id_imm = 5; step();
      next(); id_valid = 1; id_branch = 1; id_rs = 1; id_rt = 2; id_rs_used = 1;
      id_rt_used = 1; id_pc4 = 32'h100; id_imm = 5;
      mem_wen = 1; mem_dst = 1; mem_data = 77; step();

      // Writes to r0 are dropped; bne r0,r0 is not taken.
      next(); wb_wen = 1; wb_dst = 0; wb_data = 32'hFFFFFFFF;
      id_valid = 1; id_rs_used = 1; id_rt_used = 1; step();
      next(); id_valid = 1; id_branch = 1; id_bne = 1; id_rs_used = 1; id_rt_used = 1;
      id_imm = 32'hFFFFFFFF; id_pc4 = 32'h40; step();

      repeat (3000) begin
         @(negedge clk);
         rand_inputs();
         step();
      end

      // Asynchronous reset in the middle of a load-use stall.
      next(); id_valid = 1; id_load = 1; id_wen = 1; id_dst = 3; step();
      next(); id_valid = 1; id_rs = 3; id_rs_used = 1; step();
      #3;
      rst = 1'b1;
      ex_q.delete();
      #1;
      check("arst_ex_valid", XLEN'(ex_valid), '0);
      check("arst_ex_dst", XLEN'(ex_dst), '0);
      check("arst_stall_out", XLEN'(stall_out), '0);
      @(negedge clk);
      check("arst_hold_stall", XLEN'(stall_out), '0);
      rst = 1'b0;
      model_reset();
      ex_q.delete();
      comb_q.delete();

      // Register file contents are gone after reset.
      next(); id_valid = 1; id_rs = 2; id_rs_used = 1; id_rt = 5; id_rt_used = 1; step();
      next(); step();
      repeat (3) @(negedge clk);
      check("queues_drained", XLEN'(comb_q.size() + ex_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
